// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM controller port between NUM_PORTS masters. Port 0 (VGA
// read cache) has fixed priority, limited to VGA_MAX_CONSEC back-to-back
// grants while another port waits; ports 1..NUM_PORTS-1 share round-robin.
// The winner's command is latched and issued downstream; read data and
// completion are routed back to the owning port only. A watchdog releases
// the port if completion never arrives.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   m_request/address/write/wdata/wstrb   per-port command (packed by port)
//   m_ready             command accepted, owner only
//   m_rvalid/m_complete read data valid / transaction done, owner only
//   m_rdata/m_raddress  read data and address, broadcast
//   sdram_*             downstream command and return path
//   timeout_error       sticky watchdog flag; timeout_port = owner at timeout
//
// state  | meaning
// IDLE   | choosing a winner among requesting ports
// ISSUE  | latched command presented, waiting for sdram_ready
// WAIT   | command accepted, waiting for sdram_complete or watchdog
module sdram_arbiter #(
    parameter int NUM_PORTS      = 3,
    parameter int VGA_MAX_CONSEC = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    m_request,
    input  logic [NUM_PORTS*26-1:0] m_address,
    input  logic [NUM_PORTS-1:0]    m_write,
    input  logic [NUM_PORTS*32-1:0] m_wdata,
    input  logic [NUM_PORTS*4-1:0]  m_wstrb,
    output logic [NUM_PORTS-1:0]    m_ready,
    output logic [NUM_PORTS-1:0]    m_rvalid,
    output logic [31:0]             m_rdata,
    output logic [25:0]             m_raddress,
    output logic [NUM_PORTS-1:0]    m_complete,
    output logic                    sdram_request,
    input  logic                    sdram_ready,
    output logic [25:0]             sdram_address,
    output logic                    sdram_write,
    output logic [31:0]             sdram_wdata,
    output logic [3:0]              sdram_wstrb,
    input  logic                    sdram_rvalid,
    input  logic [31:0]             sdram_rdata,
    input  logic [25:0]             sdram_raddress,
    input  logic                    sdram_complete,
    output logic                    timeout_error,
    output logic [2:0]              timeout_port
);

    localparam int VW = $clog2(VGA_MAX_CONSEC + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [VW-1:0] VGA_MAX   = VW'(VGA_MAX_CONSEC);
    localparam logic [WW-1:0] WD_LOAD   = WW'(TIMEOUT_CYCLES);
    localparam logic [2:0]    LAST_PORT = 3'(NUM_PORTS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic [VW-1:0] vga_consec_q, vga_consec_d;
    logic [WW-1:0] watchdog_q, watchdog_d;
    logic          sdram_request_q, sdram_request_d;
    logic [25:0]   sdram_address_q, sdram_address_d;
    logic          sdram_write_q, sdram_write_d;
    logic [31:0]   sdram_wdata_q, sdram_wdata_d;
    logic [3:0]    sdram_wstrb_q, sdram_wstrb_d;
    logic          timeout_error_q, timeout_error_d;
    logic [2:0]    timeout_port_q, timeout_port_d;

    logic        others_req, vga_win, rr_found, grant_valid;
    logic [2:0]  rr_pick, grant_port;
    logic [25:0] sel_address;
    logic        sel_write;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    // Winner selection. The round-robin search visits ports rr_ptr+1 ..
    // NUM_PORTS-1 then wraps to 1; port 0 never takes part in it.
    always_comb begin
        int cand;
        cand        = 0;
        others_req  = |m_request[NUM_PORTS-1:1];
        vga_win     = m_request[0] && ((vga_consec_q < VGA_MAX) || !others_req);
        rr_found    = 1'b0;
        rr_pick     = 3'd0;
        for (int i = 1; i < NUM_PORTS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_PORTS) cand = cand - (NUM_PORTS - 1);
            for (int p = 1; p < NUM_PORTS; p++) begin
                if (!rr_found && p == cand && m_request[p]) begin
                    rr_found = 1'b1;
                    rr_pick  = 3'(p);
                end
            end
        end
        grant_valid = vga_win || rr_found;
        grant_port  = vga_win ? 3'd0 : rr_pick;
        sel_address = '0;
        sel_write   = 1'b0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (3'(p) == grant_port) begin
                sel_address = m_address[26*p +: 26];
                sel_write   = m_write[p];
                sel_wdata   = m_wdata[32*p +: 32];
                sel_wstrb   = m_wstrb[4*p +: 4];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        vga_consec_d    = vga_consec_q;
        watchdog_d      = watchdog_q;
        sdram_request_d = sdram_request_q;
        sdram_address_d = sdram_address_q;
        sdram_write_d   = sdram_write_q;
        sdram_wdata_d   = sdram_wdata_q;
        sdram_wstrb_d   = sdram_wstrb_q;
        timeout_error_d = timeout_error_q;
        timeout_port_d  = timeout_port_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d         = ST_ISSUE;
                    owner_d         = grant_port;
                    sdram_request_d = 1'b1;
                    sdram_address_d = sel_address;
                    sdram_write_d   = sel_write;
                    sdram_wdata_d   = sel_wdata;
                    sdram_wstrb_d   = sel_wstrb;
                    if (grant_port == 3'd0) begin
                        if (!others_req)
                            vga_consec_d = '0;
                        else if (vga_consec_q != VGA_MAX)
                            vga_consec_d = vga_consec_q + VW'(1);
                    end else begin
                        vga_consec_d = '0;
                        rr_ptr_d     = grant_port;
                    end
                end
            end
            ST_ISSUE: begin
                if (sdram_ready) begin
                    sdram_request_d = 1'b0;
                    watchdog_d      = WD_LOAD;
                    state_d         = sdram_complete ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Down-counter loaded on entry; a completion in the same
                // cycle as terminal count wins over the timeout.
                if (sdram_complete) begin
                    state_d = ST_IDLE;
                end else if (watchdog_q <= WW'(1)) begin
                    state_d         = ST_IDLE;
                    timeout_error_d = 1'b1;
                    timeout_port_d  = owner_q;
                end else begin
                    watchdog_d = watchdog_q - WW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Owner-only return path; everything is quiet in IDLE and during reset.
    always_comb begin
        m_ready    = '0;
        m_rvalid   = '0;
        m_complete = '0;
        if (!reset && state_q != ST_IDLE) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (3'(p) == owner_q) begin
                    m_ready[p]    = (state_q == ST_ISSUE) && sdram_ready;
                    m_rvalid[p]   = sdram_rvalid;
                    m_complete[p] = sdram_complete;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            owner_q         <= 3'd0;
            rr_ptr_q        <= LAST_PORT;
            vga_consec_q    <= '0;
            watchdog_q      <= '0;
            sdram_request_q <= 1'b0;
            sdram_address_q <= '0;
            sdram_write_q   <= 1'b0;
            sdram_wdata_q   <= '0;
            sdram_wstrb_q   <= '0;
            timeout_error_q <= 1'b0;
            timeout_port_q  <= 3'd0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            vga_consec_q    <= vga_consec_d;
            watchdog_q      <= watchdog_d;
            sdram_request_q <= sdram_request_d;
            sdram_address_q <= sdram_address_d;
            sdram_write_q   <= sdram_write_d;
            sdram_wdata_q   <= sdram_wdata_d;
            sdram_wstrb_q   <= sdram_wstrb_d;
            timeout_error_q <= timeout_error_d;
            timeout_port_q  <= timeout_port_d;
        end
    end

    assign sdram_request = sdram_request_q;
    assign sdram_address = sdram_address_q;
    assign sdram_write   = sdram_write_q;
    assign sdram_wdata   = sdram_wdata_q;
    assign sdram_wstrb   = sdram_wstrb_q;
    assign timeout_error = timeout_error_q;
    assign timeout_port  = timeout_port_q;
    assign m_rdata       = sdram_rdata;
    assign m_raddress    = sdram_raddress;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between NUM_PORTS masters: port 0 is the VGA read cache (real-time), ports 1..NUM_PORTS-1 are the CPU, blitter and similar masters.
- Grants one transaction at a time, latches the winner's command, forwards it downstream, then routes read data and completion back to the owner only.
- Provides fixed priority for port 0 with an anti-starvation limit, round-robin among the other ports, and a completion watchdog.

Parameters:
- NUM_PORTS, 3, number of masters (2..8).
- VGA_MAX_CONSEC, 4, maximum consecutive port-0 grants while another port is pending.
- TIMEOUT_CYCLES, 1023, cycles allowed in WAIT before a forced release.

Ports:
- clock  in  1  system clock (125MHz)
- reset  in  1  synchronous, active-high
- m_request  in  NUM_PORTS  per-port request, held until m_ready
- m_address  in  NUM_PORTS*26  per-port address; port p uses bits [26p+25:26p]
- m_write  in  NUM_PORTS  1 = write, 0 = read burst
- m_wdata  in  NUM_PORTS*32  per-port write data
- m_wstrb  in  NUM_PORTS*4  per-port byte enables
- m_ready  out  NUM_PORTS  command accepted (one-hot or zero)
- m_rvalid  out  NUM_PORTS  read data valid, owner only
- m_rdata  out  32  read data, broadcast to all ports
- m_raddress  out  26  read data address, broadcast to all ports
- m_complete  out  NUM_PORTS  transaction complete, owner only
- sdram_request  out  1  downstream request
- sdram_ready  in  1  downstream accept
- sdram_address  out  26  latched address
- sdram_write  out  1  latched write flag
- sdram_wdata  out  32  latched write data
- sdram_wstrb  out  4  latched byte enables
- sdram_rvalid  in  1  downstream read data valid
- sdram_rdata  in  32  downstream read data
- sdram_raddress  in  26  downstream read data address
- sdram_complete  in  1  downstream transaction complete
- timeout_error  out  1  sticky; set when the watchdog fires
- timeout_port  out  3  owner at the last timeout

Behaviour:
- Reset values:
  - state=IDLE; owner=0; rr_ptr=NUM_PORTS-1; vga_consec=0; watchdog=0.
  - sdram_request=0; sdram_address/wdata/wstrb/write=0.
  - timeout_error=0; timeout_port=0.
  - m_ready, m_rvalid and m_complete all 0.
- States IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, winner selection (evaluated every cycle):
  - If m_request[0]=1 and (vga_consec<VGA_MAX_CONSEC or no other port requesting), port 0 wins.
  - Otherwise the first requesting port in 1..NUM_PORTS-1, searched from rr_ptr+1 with wrap, skipping 0.
  - If only port 0 requests, it always wins regardless of vga_consec.
- IDLE, on a winner:
  - Latch owner and that port's address/write/wdata/wstrb into the sdram_* registers; set sdram_request=1 next cycle; go to ISSUE.
  - Grant registered: request at cycle N gives sdram_request=1 at N+1.
- vga_consec update on each grant:
  - Port 0 grant while another port is pending: increment, saturating.
  - Grant to any other port: clear to 0.
  - Port 0 grant with nothing else pending: clear to 0.
- rr_ptr is updated to owner on any grant to a port other than 0.
- ISSUE:
  - sdram_request held at 1 and the latched command held stable.
  - m_ready[owner] = sdram_ready (combinational); all other m_ready bits are 0.
  - On sdram_ready: sdram_request=0 next cycle; go to WAIT.
  - If sdram_ready and sdram_complete occur in the same cycle, go straight to IDLE.
- WAIT:
  - On sdram_complete: go to IDLE. The next grant can issue the following cycle, so a back-to-back gap is 1 IDLE cycle.
- Return path (ISSUE and WAIT):
  - m_rvalid[owner]=sdram_rvalid; m_complete[owner]=sdram_complete; other bits 0.
  - In IDLE, all m_rvalid and m_complete bits are 0.
  - m_rdata and m_raddress pass through unregistered.
- Masters must hold m_request until m_ready; changes to m_address etc. after the grant are ignored because the command is latched.
- A master dropping its request during ISSUE does not cancel the transaction; it still completes and is routed to that port.
- Watchdog:
  - Counts cycles in WAIT and clears on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, set timeout_error=1 and timeout_port=owner.
  - A late sdram_complete arriving in IDLE is dropped.
  - timeout_error is cleared only by reset.
- Reset mid-transaction: returns to IDLE immediately; sdram_request=0 next cycle; no m_complete is issued.

Test Plan:
- Port 1 requests alone, addr 0x0001234 -> sdram_request=1 one cycle later with sdram_address=0x0001234; m_ready[1] in the same cycle as sdram_ready; m_complete[1] pulses on sdram_complete; m_complete[0] and m_complete[2] stay 0.
- Ports 0, 1 and 2 request continuously, VGA_MAX_CONSEC=4 -> grant order 0,0,0,0,1,0,0,0,0,2,0,0,0,0,1...
- Ports 1 and 2 request continuously, port 0 idle -> grants alternate 1,2,1,2; 4 read bursts of 8 rvalid beats each land only on the owner's m_rvalid.
- Port 2 granted, port 2 changes m_address to 0x3FFFFFF during ISSUE -> sdram_address stays at the latched value; sdram_ready and sdram_complete in the same cycle -> back to IDLE, next grant issues 1 cycle later.
- TIMEOUT_CYCLES=15, sdram_complete withheld after the port 1 accept -> 15 cycles in WAIT, then IDLE with timeout_error=1 and timeout_port=1; a late sdram_complete produces no m_complete pulse.
- Reset asserted during WAIT -> the next cycle shows state IDLE, all outputs at reset values, timeout_error=0.
